// File: rtl/panel_scan_mux_pkg.sv
// Shared front-panel definitions: default lamp width, channel index map and the scan-mode enum.
// Callers use the CH_* constants so every site packs ch_data in the same order.
package panel_scan_mux_pkg;

    localparam int PANEL_W   = 12;
    localparam int PANEL_NCH = 6;

    localparam int CH_STATE  = 0;
    localparam int CH_STATUS = 1;
    localparam int CH_AC     = 2;
    localparam int CH_MB     = 3;
    localparam int CH_MQ     = 4;
    localparam int CH_BUS    = 5;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Channel index width, kept at one bit even for a single channel.
    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/panel_scan_mux_if.sv
// Panel mux bus: channel sources and switches in, lamp data and status out.
// lamp_test exists only when PANEL_LAMP_TEST_EN is defined.
interface panel_scan_mux_if #(
    parameter int W   = 12,
    parameter int NCH = 6
);
    import panel_scan_mux_pkg::*;

    localparam int IDXW = idx_width(NCH);

    logic [NCH-1:0]   dsel;
    logic [NCH*W-1:0] ch_data;
    logic             freeze;
    logic             cpu_run;
    logic             sw_active;
`ifdef PANEL_LAMP_TEST_EN
    logic             lamp_test;
`endif
    logic [W-1:0]     dout;
    logic [IDXW-1:0]  chan_idx;
    logic             scan_active;
    logic             run_led;

`ifdef PANEL_LAMP_TEST_EN
    modport master (
        output dsel, ch_data, freeze, cpu_run, sw_active, lamp_test,
        input  dout, chan_idx, scan_active, run_led
    );
    modport slave (
        input  dsel, ch_data, freeze, cpu_run, sw_active, lamp_test,
        output dout, chan_idx, scan_active, run_led
    );
`else
    modport master (
        output dsel, ch_data, freeze, cpu_run, sw_active,
        input  dout, chan_idx, scan_active, run_led
    );
    modport slave (
        input  dsel, ch_data, freeze, cpu_run, sw_active,
        output dout, chan_idx, scan_active, run_led
    );
`endif

endinterface

// File: rtl/panel_scan_mux_led_stretch.sv
// RUN lamp stretcher (led_stretch): holds the lamp STRETCH clocks after activity drops.
// force_on lights the lamp without disturbing the stretch counter.
module panel_scan_mux_led_stretch #(
    parameter int STRETCH = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic act,
    input  logic force_on,
    output logic run_led
);

    localparam int CW = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;

    logic [CW-1:0] stretch_cnt;
    logic          led_next;

    // With STRETCH=0 the counter never leaves zero, so the lamp is just act delayed one clock.
    assign led_next = act || (stretch_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stretch_cnt <= '0;
            run_led     <= 1'b0;
        end else begin
            if (act) begin
                stretch_cnt <= CW'(STRETCH);
            end else if (stretch_cnt != '0) begin
                stretch_cnt <= stretch_cnt - 1'b1;
            end
            run_led <= led_next || force_on;
        end
    end

endmodule

// File: rtl/panel_scan_mux.sv
// Front-panel display multiplexer: manual one-hot channel select or auto-scan, freeze, RUN lamp.
// Define PANEL_LAMP_TEST_EN to add the lamp_test override (all data lamps and RUN lamp on).
module panel_scan_mux
    import panel_scan_mux_pkg::*;
#(
    parameter int W        = PANEL_W,
    parameter int NCH      = PANEL_NCH,
    parameter int SCAN_DIV = 1024,
    parameter int STRETCH  = 4096
) (
    input logic             clk,
    input logic             reset,
    panel_scan_mux_if.slave bus
);

    localparam int IDXW = idx_width(NCH);
    localparam int CNTW = $clog2(SCAN_DIV);

    mode_e           state;
    mode_e           state_next;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] idx_next;
    logic [IDXW-1:0] winner;
    logic [CNTW-1:0] scan_cnt;
    logic [CNTW-1:0] cnt_next;
    logic [W-1:0]    dout_q;
    logic [W-1:0]    dout_next;
    logic            lamp_hold;
    logic            force_on;

    // Highest raised selector wins, so later loop iterations overwrite earlier ones.
    always_comb begin
        winner = '0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.dsel[k]) begin
                winner = IDXW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MODE_MANUAL;
        end else begin
            state <= state_next;
        end
    end

    // Selector switches override a pending scan step; freeze pins index and dwell counter
    // but the mode still follows the switches.
    always_comb begin
        state_next = (bus.dsel != '0) ? MODE_MANUAL : MODE_SCAN;
        idx_next   = idx_q;
        cnt_next   = scan_cnt;
        if (!bus.freeze) begin
            if (state_next == MODE_MANUAL) begin
                idx_next = winner;
                cnt_next = '0;
            end else if (scan_cnt == CNTW'(SCAN_DIV - 1)) begin
                cnt_next = '0;
                idx_next = (idx_q == IDXW'(NCH - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_next = scan_cnt + 1'b1;
            end
        end

        dout_next = bus.ch_data[idx_next*W +: W];
        if (bus.freeze && !lamp_hold) begin
            dout_next = dout_q;
        end
`ifdef PANEL_LAMP_TEST_EN
        if (bus.lamp_test) begin
            dout_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            scan_cnt <= '0;
            dout_q   <= '0;
        end else begin
            idx_q    <= idx_next;
            scan_cnt <= cnt_next;
            dout_q   <= dout_next;
        end
    end

`ifdef PANEL_LAMP_TEST_EN
    // Remembers that the lamps show the test pattern, so leaving lamp test reloads real
    // channel data even while frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lamp_hold <= 1'b0;
        end else begin
            lamp_hold <= bus.lamp_test;
        end
    end
    assign force_on = bus.lamp_test;
`else
    assign lamp_hold = 1'b0;
    assign force_on  = 1'b0;
`endif

    panel_scan_mux_led_stretch #(
        .STRETCH (STRETCH)
    ) u_led_stretch (
        .clk      (clk),
        .reset    (reset),
        .act      (bus.cpu_run || bus.sw_active),
        .force_on (force_on),
        .run_led  (bus.run_led)
    );

    assign bus.dout        = dout_q;
    assign bus.chan_idx    = idx_q;
    assign bus.scan_active = (state == MODE_SCAN);

endmodule

// File: tb/tb_panel_scan_mux.sv
// Self-checking bench for panel_scan_mux: vector table for select/scan, hand sequences for
// freeze, RUN stretch, async reset and (with PANEL_LAMP_TEST_EN) lamp test.
module tb_panel_scan_mux;
    import panel_scan_mux_pkg::*;

    localparam int W        = 12;
    localparam int NCH      = 6;
    localparam int SCAN_DIV = 4;
    localparam int STRETCH  = 8;
    localparam int IDXW     = 3;

    typedef struct {
        logic [IDXW-1:0] idx;
        logic [W-1:0]    dout;
        logic            scan;
        logic            led;
    } exp_t;

    typedef struct {
        logic [NCH-1:0] dsel;
        int             exp_idx;
        logic           exp_scan;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [W-1:0] chv [NCH];
    exp_t        sb_q [$];
    vec_t        vecs [26];
    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;

    always #5 clk = ~clk;

    panel_scan_mux_if #(.W(W), .NCH(NCH)) bus ();

    panel_scan_mux #(
        .W        (W),
        .NCH      (NCH),
        .SCAN_DIV (SCAN_DIV),
        .STRETCH  (STRETCH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step_no, got, exp);
        end
    endtask

    task automatic drive_channels();
        for (int k = 0; k < NCH; k++) begin
            bus.ch_data[k*W +: W] = chv[k];
        end
    endtask

    task automatic apply_stimulus(input logic [NCH-1:0] dsel, input logic fr, input logic run,
                                  input logic sw, input exp_t e);
        @(negedge clk);
        bus.dsel      = dsel;
        bus.freeze    = fr;
        bus.cpu_run   = run;
        bus.sw_active = sw;
        drive_channels();
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        if (sb_q.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            cmp("chan_idx", 32'(bus.chan_idx), 32'(e.idx));
            cmp("dout", 32'(bus.dout), 32'(e.dout));
            cmp("scan_active", 32'(bus.scan_active), 32'(e.scan));
            cmp("run_led", 32'(bus.run_led), 32'(e.led));
        end
    endtask

    task automatic step(input logic [NCH-1:0] dsel, input logic fr, input logic run, input logic sw,
                        input int eidx, input logic [W-1:0] edout, input logic escan,
                        input logic eled);
        exp_t e;
        e.idx  = IDXW'(eidx);
        e.dout = edout;
        e.scan = escan;
        e.led  = eled;
        apply_stimulus(dsel, fr, run, sw, e);
        check_output();
    endtask

    initial begin
        logic [W-1:0] old5;
        int           idx_seq [4];

        for (int k = 0; k < NCH; k++) begin
            chv[k] = W'((k + 1) * 65);
        end
        chv[CH_AC] = 12'o1234;

        reset         = 1'b1;
        bus.dsel      = 6'b000100;
        bus.freeze    = 1'b0;
        bus.cpu_run   = 1'b0;
        bus.sw_active = 1'b0;
`ifdef PANEL_LAMP_TEST_EN
        bus.lamp_test = 1'b0;
`endif
        drive_channels();

        // Reset state, then the first selected channel one clock after release.
        repeat (2) @(negedge clk);
        cmp("reset_dout", 32'(bus.dout), 32'd0);
        cmp("reset_idx", 32'(bus.chan_idx), 32'd0);
        cmp("reset_scan", 32'(bus.scan_active), 32'd0);
        cmp("reset_led", 32'(bus.run_led), 32'd0);
        reset = 1'b0;
        step(6'b000100, 1'b0, 1'b0, 1'b0, CH_AC, 12'o1234, 1'b0, 1'b0);

        // Auto-scan from index 2 with a 4-clock dwell, select overriding a due step,
        // priority of the highest selector, then scan resuming from the manual index.
        vecs = '{
            '{6'b000000, 2, 1'b1}, '{6'b000000, 2, 1'b1}, '{6'b000000, 2, 1'b1},
            '{6'b000000, 3, 1'b1}, '{6'b000000, 3, 1'b1}, '{6'b000000, 3, 1'b1},
            '{6'b000000, 3, 1'b1}, '{6'b000000, 4, 1'b1}, '{6'b000000, 4, 1'b1},
            '{6'b000000, 4, 1'b1}, '{6'b000000, 4, 1'b1}, '{6'b000000, 5, 1'b1},
            '{6'b000000, 5, 1'b1}, '{6'b000000, 5, 1'b1}, '{6'b000000, 5, 1'b1},
            '{6'b000000, 0, 1'b1}, '{6'b000000, 0, 1'b1}, '{6'b000000, 0, 1'b1},
            '{6'b000000, 0, 1'b1}, '{6'b100001, 5, 1'b0}, '{6'b010010, 4, 1'b0},
            '{6'b010010, 4, 1'b0}, '{6'b000000, 4, 1'b1}, '{6'b000000, 4, 1'b1},
            '{6'b000000, 4, 1'b1}, '{6'b000000, 5, 1'b1}
        };
        foreach (vecs[i]) begin
            step(vecs[i].dsel, 1'b0, 1'b0, 1'b0, vecs[i].exp_idx, chv[vecs[i].exp_idx],
                 vecs[i].exp_scan, 1'b0);
        end

        // Freeze mid-dwell while the channel data changes; release completes the dwell.
        step(6'b000000, 1'b0, 1'b0, 1'b0, 5, chv[5], 1'b1, 1'b0);
        old5   = chv[5];
        chv[5] = 12'o7070;
        chv[0] = 12'o4321;
        step(6'b000000, 1'b1, 1'b0, 1'b0, 5, old5, 1'b1, 1'b0);
        step(6'b000001, 1'b1, 1'b0, 1'b0, 5, old5, 1'b0, 1'b0);
        step(6'b000000, 1'b1, 1'b0, 1'b0, 5, old5, 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 5, 12'o7070, 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 5, 12'o7070, 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 0, 12'o4321, 1'b1, 1'b0);

        // RUN lamp: one-clock pulse lights it for STRETCH+1 clocks.
        step(6'b001000, 1'b0, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b0);
        step(6'b001000, 1'b0, 1'b1, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b1);
        for (int i = 0; i < STRETCH; i++) begin
            step(6'b001000, 1'b0, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b1);
        end
        step(6'b001000, 1'b0, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b0);
        step(6'b001000, 1'b0, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b0);

        // Held switch activity keeps the lamp lit, freeze has no effect on it.
        for (int i = 0; i < 12; i++) begin
            step(6'b001000, (i % 2 == 0), 1'b0, 1'b1, CH_MB, chv[CH_MB], 1'b0, 1'b1);
        end
        for (int i = 0; i < STRETCH; i++) begin
            step(6'b001000, 1'b1, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b1);
        end
        step(6'b001000, 1'b0, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b0, 1'b0);

        // Async reset mid-dwell and mid-stretch clears everything at once.
        step(6'b000000, 1'b0, 1'b1, 1'b0, CH_MB, chv[CH_MB], 1'b1, 1'b1);
        step(6'b000000, 1'b0, 1'b0, 1'b0, CH_MB, chv[CH_MB], 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmp("midrun_reset_dout", 32'(bus.dout), 32'd0);
        cmp("midrun_reset_idx", 32'(bus.chan_idx), 32'd0);
        cmp("midrun_reset_scan", 32'(bus.scan_active), 32'd0);
        cmp("midrun_reset_led", 32'(bus.run_led), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idx_seq = '{0, 0, 0, 1};
        foreach (idx_seq[i]) begin
            step(6'b000000, 1'b0, 1'b0, 1'b0, idx_seq[i], chv[idx_seq[i]], 1'b1, 1'b0);
        end

`ifdef PANEL_LAMP_TEST_EN
        // Lamp test overrides freeze; release shows the held channel again.
        bus.lamp_test = 1'b1;
        step(6'b000000, 1'b1, 1'b0, 1'b0, 1, 12'o7777, 1'b1, 1'b1);
        step(6'b000000, 1'b1, 1'b0, 1'b0, 1, 12'o7777, 1'b1, 1'b1);
        bus.lamp_test = 1'b0;
        step(6'b000000, 1'b1, 1'b0, 1'b0, 1, chv[1], 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1, chv[1], 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1, chv[1], 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 1, chv[1], 1'b1, 1'b0);
        step(6'b000000, 1'b0, 1'b0, 1'b0, 2, chv[2], 1'b1, 1'b0);
`endif

        cmp("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
